// File: rtl/arm7tdmi_decode_checker.sv
// Stream checker for arm7tdmi_decode: queues expectations, compares decoder results in order.
// Optional class-coverage bitmaps are enabled with `define DECODE_CHECK_COV_EN.
module arm7tdmi_decode_checker #(
    parameter int DEPTH    = 4,
    parameter int CNT_W    = 16,
    parameter int ARM_TW   = 4,
    parameter int THUMB_TW = 5,
    parameter int TIMEOUT  = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   finish,
    input  logic                   stim_valid,
    output logic                   stim_ready,
    input  logic [31:0]            stim_instr,
    input  logic                   stim_thumb,
    input  logic [THUMB_TW-1:0]    stim_exp,
    output logic [31:0]            drv_instr,
    output logic                   drv_thumb,
    output logic                   drv_valid,
    input  logic                   dec_valid,
    input  logic [ARM_TW-1:0]      dec_type,
    input  logic [THUMB_TW-1:0]    dec_thumb_type,
    output logic [CNT_W-1:0]       arm_pass,
    output logic [CNT_W-1:0]       arm_fail,
    output logic [CNT_W-1:0]       thumb_pass,
    output logic [CNT_W-1:0]       thumb_fail,
    output logic [CNT_W-1:0]       orphan_cnt,
    output logic                   busy,
    output logic                   done,
    output logic                   timed_out,
    output logic                   all_pass,
    output logic                   mm_valid,
    output logic [31:0]            mm_instr,
    output logic [THUMB_TW-1:0]    mm_exp,
    output logic [THUMB_TW-1:0]    mm_got,
    output logic [2**ARM_TW-1:0]   arm_cov,
    output logic [2**THUMB_TW-1:0] thumb_cov
);

    localparam int PW = $clog2(DEPTH);
    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t state, state_nx;

    logic [31:0]         fifo_instr [DEPTH];
    logic                fifo_thumb [DEPTH];
    logic [THUMB_TW-1:0] fifo_exp   [DEPTH];

    logic [PW-1:0]       wr_ptr, rd_ptr, wr_addr;
    logic [PW:0]         count;
    logic [IW-1:0]       idle_cnt;
    logic                full, empty, active, accept, pop, orphan;
    logic                head_thumb, match, timeout_hit;
    logic [31:0]         head_instr;
    logic [THUMB_TW-1:0] head_exp, got;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign full       = (count == (PW+1)'(DEPTH));
    assign empty      = (count == '0);
    assign active     = (state == S_RUN) || (state == S_DRAIN);
    assign stim_ready = (state == S_RUN) && !full;
    assign accept     = stim_valid && stim_ready;
    // A start in the same cycle discards any pending compare.
    assign pop        = dec_valid && active && !empty && !start;
    assign orphan     = dec_valid && active && empty && !start;
    assign wr_addr    = start ? '0 : wr_ptr;

    assign head_instr = fifo_instr[rd_ptr];
    assign head_thumb = fifo_thumb[rd_ptr];
    assign head_exp   = fifo_exp[rd_ptr];
    assign match      = head_thumb ? (dec_thumb_type == head_exp)
                                   : (dec_type == head_exp[ARM_TW-1:0]);
    assign got        = head_thumb ? dec_thumb_type : THUMB_TW'(dec_type);

    assign busy     = active;
    assign done     = (state == S_DONE);
    assign all_pass = done && !timed_out && (arm_fail == '0) && (thumb_fail == '0) &&
                      (orphan_cnt == '0) && ((arm_pass != '0) || (thumb_pass != '0));

    always_comb begin
        state_nx    = state;
        timeout_hit = 1'b0;
        if (start) begin
            state_nx = S_RUN;
        end else begin
            case (state)
                S_RUN:   if (finish) state_nx = S_DRAIN;
                S_DRAIN: begin
                    if (empty) begin
                        state_nx = S_DONE;
                    end else if (idle_cnt == IW'(TIMEOUT)) begin
                        state_nx    = S_DONE;
                        timeout_hit = 1'b1;
                    end
                end
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_instr[wr_addr] <= stim_instr;
            fifo_thumb[wr_addr] <= stim_thumb;
            fifo_exp[wr_addr]   <= stim_exp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (start) begin
            wr_ptr <= PW'(accept);
            rd_ptr <= '0;
            count  <= (PW+1)'(accept);
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(accept) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drv_instr <= '0;
            drv_thumb <= 1'b0;
            drv_valid <= 1'b0;
        end else begin
            drv_valid <= accept;
            if (accept) begin
                drv_instr <= stim_instr;
                drv_thumb <= stim_thumb;
            end
        end
    end

    // Idle counter only runs in DRAIN; it parks at TIMEOUT until the state leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              idle_cnt <= '0;
        else if (state != S_DRAIN || start)      idle_cnt <= '0;
        else if (dec_valid)                      idle_cnt <= '0;
        else if (idle_cnt != IW'(TIMEOUT))       idle_cnt <= idle_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_pass   <= '0;
            arm_fail   <= '0;
            thumb_pass <= '0;
            thumb_fail <= '0;
            orphan_cnt <= '0;
            timed_out  <= 1'b0;
            mm_valid   <= 1'b0;
            mm_instr   <= '0;
            mm_exp     <= '0;
            mm_got     <= '0;
        end else if (start) begin
            arm_pass   <= '0;
            arm_fail   <= '0;
            thumb_pass <= '0;
            thumb_fail <= '0;
            orphan_cnt <= '0;
            timed_out  <= 1'b0;
            mm_valid   <= 1'b0;
            mm_instr   <= '0;
            mm_exp     <= '0;
            mm_got     <= '0;
        end else begin
            if (timeout_hit) timed_out <= 1'b1;
            if (orphan)      orphan_cnt <= sat_inc(orphan_cnt);
            if (pop) begin
                if (match) begin
                    if (head_thumb) thumb_pass <= sat_inc(thumb_pass);
                    else            arm_pass   <= sat_inc(arm_pass);
                end else begin
                    if (head_thumb) thumb_fail <= sat_inc(thumb_fail);
                    else            arm_fail   <= sat_inc(arm_fail);
                    if (!mm_valid) begin
                        mm_valid <= 1'b1;
                        mm_instr <= head_instr;
                        mm_exp   <= head_exp;
                        mm_got   <= got;
                    end
                end
            end
        end
    end

`ifdef DECODE_CHECK_COV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_cov   <= '0;
            thumb_cov <= '0;
        end else if (start) begin
            arm_cov   <= '0;
            thumb_cov <= '0;
        end else if (pop && match) begin
            if (head_thumb) thumb_cov[head_exp]             <= 1'b1;
            else            arm_cov[head_exp[ARM_TW-1:0]]   <= 1'b1;
        end
    end
`else
    assign arm_cov   = '0;
    assign thumb_cov = '0;
`endif

endmodule

// File: tb/tb_arm7tdmi_decode_checker.sv
// Directed, table-driven bench for arm7tdmi_decode_checker; the bench plays the decoder.
module tb_arm7tdmi_decode_checker;

    localparam logic [3:0] INSTR_DATA_PROC = 4'd0;
    localparam logic [3:0] INSTR_MUL       = 4'd1;
    localparam logic [3:0] INSTR_LDR_STR   = 4'd4;
    localparam logic [3:0] INSTR_BRANCH    = 4'd9;
    localparam logic [3:0] INSTR_SWI       = 4'd12;
    localparam logic [4:0] THUMB_ALU       = 5'd4;
    localparam logic [4:0] THUMB_ALU_HI    = 5'd6;
    localparam logic [4:0] THUMB_LDR_PC    = 5'd7;
    localparam logic [4:0] THUMB_BRANCH_UNCOND = 5'd17;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, finish = 1'b0;
    logic        stim_valid = 1'b0, stim_thumb = 1'b0;
    logic [31:0] stim_instr = '0;
    logic [4:0]  stim_exp = '0;
    logic        stim_ready;
    logic [31:0] drv_instr;
    logic        drv_thumb, drv_valid;
    logic        dec_valid = 1'b0;
    logic [3:0]  dec_type = '0;
    logic [4:0]  dec_thumb_type = '0;
    logic [15:0] arm_pass, arm_fail, thumb_pass, thumb_fail, orphan_cnt;
    logic        busy, done, timed_out, all_pass, mm_valid;
    logic [31:0] mm_instr;
    logic [4:0]  mm_exp, mm_got;
    logic [15:0] arm_cov;
    logic [31:0] thumb_cov;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic        thumb;
        logic [4:0]  exp;
        logic [3:0]  ret_arm;
        logic [4:0]  ret_thumb;
        logic        pass;
    } vec_t;

    vec_t vecs [6];

    arm7tdmi_decode_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .stim_valid(stim_valid), .stim_ready(stim_ready), .stim_instr(stim_instr),
        .stim_thumb(stim_thumb), .stim_exp(stim_exp),
        .drv_instr(drv_instr), .drv_thumb(drv_thumb), .drv_valid(drv_valid),
        .dec_valid(dec_valid), .dec_type(dec_type), .dec_thumb_type(dec_thumb_type),
        .arm_pass(arm_pass), .arm_fail(arm_fail), .thumb_pass(thumb_pass),
        .thumb_fail(thumb_fail), .orphan_cnt(orphan_cnt),
        .busy(busy), .done(done), .timed_out(timed_out), .all_pass(all_pass),
        .mm_valid(mm_valid), .mm_instr(mm_instr), .mm_exp(mm_exp), .mm_got(mm_got),
        .arm_cov(arm_cov), .thumb_cov(thumb_cov)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic thumb, input logic [4:0] exp);
        int n;
        stim_valid = 1'b1;
        stim_instr = instr;
        stim_thumb = thumb;
        stim_exp   = exp;
        n = 0;
        while (!stim_ready && n < 20) begin
            tick();
            n++;
        end
        if (!stim_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL push_ready: got 0x0 expected 0x1");
        end
        tick();
        stim_valid = 1'b0;
    endtask

    task automatic decodeReturn(input logic [3:0] a, input logic [4:0] t);
        dec_valid      = 1'b1;
        dec_type       = a;
        dec_thumb_type = t;
        tick();
        dec_valid = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulseFinish();
        finish = 1'b1;
        tick();
        finish = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_done: got 0x0 expected 0x1");
        end
    endtask

    initial begin
        int ap, af, tp, tf;

        vecs[0] = '{32'hE0000291, 1'b0, 5'(INSTR_MUL),     INSTR_MUL,       5'h1F,               1'b1};
        vecs[1] = '{32'h00004700, 1'b1, THUMB_ALU_HI,      4'hF,            THUMB_BRANCH_UNCOND, 1'b0};
        vecs[2] = '{32'hE5912000, 1'b0, 5'h14,             INSTR_LDR_STR,   5'h1F,               1'b1};
        vecs[3] = '{32'h00004008, 1'b1, THUMB_ALU,         4'hF,            THUMB_ALU,           1'b1};
        vecs[4] = '{32'hEA000000, 1'b0, 5'(INSTR_BRANCH),  INSTR_DATA_PROC, 5'h1F,               1'b0};
        vecs[5] = '{32'h00004B01, 1'b1, THUMB_LDR_PC,      4'hF,            THUMB_LDR_PC,        1'b1};

        // Reset values
        tick();
        tick();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_ready", stim_ready, 0);
        checkOutput("rst_drv_valid", drv_valid, 0);
        checkOutput("rst_drv_instr", drv_instr, 0);
        checkOutput("rst_arm_pass", arm_pass, 0);
        checkOutput("rst_mm_valid", mm_valid, 0);
        rst_n = 1'b1;
        tick();

        // Single ARM pass then clean drain
        pulseStart();
        checkOutput("run_busy", busy, 1);
        checkOutput("run_ready", stim_ready, 1);
        applyStimulus(32'hE0820001, 1'b0, 5'(INSTR_DATA_PROC));
        checkOutput("drv_valid_1", drv_valid, 1);
        checkOutput("drv_instr_1", drv_instr, 32'hE0820001);
        checkOutput("drv_thumb_1", drv_thumb, 0);
        decodeReturn(INSTR_DATA_PROC, 5'h1F);
        checkOutput("drv_valid_low", drv_valid, 0);
        checkOutput("t1_arm_pass", arm_pass, 1);
        pulseFinish();
        waitDone(10);
        checkOutput("t1_done", done, 1);
        checkOutput("t1_timed_out", timed_out, 0);
        checkOutput("t1_all_pass", all_pass, 1);

        // Table of mixed ARM/Thumb vectors including two mismatches
        pulseStart();
        checkOutput("start_clr_arm_pass", arm_pass, 0);
        ap = 0; af = 0; tp = 0; tf = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].instr, vecs[i].thumb, vecs[i].exp);
            checkOutput($sformatf("v%0d_drv_instr", i), drv_instr, vecs[i].instr);
            checkOutput($sformatf("v%0d_drv_thumb", i), drv_thumb, vecs[i].thumb);
            decodeReturn(vecs[i].ret_arm, vecs[i].ret_thumb);
            if (vecs[i].thumb) begin
                if (vecs[i].pass) tp++; else tf++;
            end else begin
                if (vecs[i].pass) ap++; else af++;
            end
            checkOutput($sformatf("v%0d_arm_pass", i), arm_pass, ap);
            checkOutput($sformatf("v%0d_arm_fail", i), arm_fail, af);
            checkOutput($sformatf("v%0d_thumb_pass", i), thumb_pass, tp);
            checkOutput($sformatf("v%0d_thumb_fail", i), thumb_fail, tf);
        end
        checkOutput("mm_valid", mm_valid, 1);
        checkOutput("mm_instr", mm_instr, 32'h00004700);
        checkOutput("mm_exp", mm_exp, THUMB_ALU_HI);
        checkOutput("mm_got", mm_got, THUMB_BRANCH_UNCOND);
        pulseFinish();
        waitDone(10);
        checkOutput("t2_done", done, 1);
        checkOutput("t2_all_pass", all_pass, 0);

        // Fill the FIFO with no results, then release one slot
        pulseStart();
        checkOutput("start_clr_mm", mm_valid, 0);
        for (int i = 0; i < 4; i++) applyStimulus(32'hE1A00000 + i, 1'b0, 5'(i + 1));
        checkOutput("full_ready", stim_ready, 0);
        stim_valid = 1'b1;
        stim_instr = 32'hE1A00004;
        stim_thumb = 1'b0;
        stim_exp   = 5'd5;
        decodeReturn(4'd1, 5'h1F);
        checkOutput("after_pop_ready", stim_ready, 1);
        checkOutput("after_pop_arm_pass", arm_pass, 1);
        tick();
        stim_valid = 1'b0;
        checkOutput("fifth_drv_instr", drv_instr, 32'hE1A00004);
        for (int i = 2; i <= 5; i++) decodeReturn(4'(i), 5'h1F);
        checkOutput("fill_arm_pass", arm_pass, 5);
        checkOutput("fill_arm_fail", arm_fail, 0);

        // Orphan result with an empty FIFO
        decodeReturn(INSTR_DATA_PROC, 5'h0);
        checkOutput("orphan_cnt", orphan_cnt, 1);
        checkOutput("orphan_arm_pass", arm_pass, 5);
        checkOutput("orphan_arm_fail", arm_fail, 0);

        // Drain timeout with two entries outstanding
        applyStimulus(32'hE0810002, 1'b0, 5'(INSTR_DATA_PROC));
        applyStimulus(32'hE0810003, 1'b0, 5'(INSTR_DATA_PROC));
        pulseFinish();
        for (int i = 0; i < 30; i++) tick();
        checkOutput("drain_busy", busy, 1);
        checkOutput("drain_not_done", done, 0);
        waitDone(100);
        checkOutput("to_done", done, 1);
        checkOutput("to_timed_out", timed_out, 1);
        checkOutput("to_all_pass", all_pass, 0);
        checkOutput("to_busy", busy, 0);
        decodeReturn(INSTR_DATA_PROC, 5'h0);
        checkOutput("done_ignores_orphan", orphan_cnt, 1);
        checkOutput("done_ignores_pass", arm_pass, 5);

        // Coverage bitmaps
        pulseStart();
        checkOutput("restart_timed_out", timed_out, 0);
        applyStimulus(32'hEF000000, 1'b0, 5'(INSTR_SWI));
        decodeReturn(INSTR_SWI, 5'h1F);
        checkOutput("swi_arm_pass", arm_pass, 1);
`ifdef DECODE_CHECK_COV_EN
        checkOutput("arm_cov_swi", arm_cov[INSTR_SWI], 1);
        checkOutput("arm_cov_other", arm_cov & ~(16'h1 << INSTR_SWI), 0);
        pulseStart();
        checkOutput("arm_cov_cleared", arm_cov, 0);
`else
        checkOutput("arm_cov_tied", arm_cov, 0);
        checkOutput("thumb_cov_tied", thumb_cov, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arm7tdmi_decode_checker.md
Name: arm7tdmi_decode_checker

Overview:
Synthesizable self-checking harness for arm7tdmi_decode that supersedes fixed-latency, one-instruction-at-a-time decode checking. It accepts a stream of {instruction, mode, expected type} over a valid/ready handshake and drives the decoder. It queues expectations to absorb arbitrary decode latency and stalls, then compares each decode_valid result in order. Per-mode pass/fail counters, first-mismatch capture, a drain/timeout state machine and optional class-coverage bitmaps make it usable in simulation and on FPGA.

Parameters:
DEPTH, 4, expectation FIFO entries (power of 2, >=2)
CNT_W, 16, width of every counter (saturating)
ARM_TW, 4, width of instr_type_t encoding
THUMB_TW, 5, width of thumb_instr_type_t encoding
TIMEOUT, 64, idle cycles in DRAIN before aborting

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: clear all results, enter RUN
finish  in  1  pulse: no more stimulus, enter DRAIN
stim_valid  in  1  stimulus offered
stim_ready  out  1  stimulus accepted this cycle when both high
stim_instr  in  32  instruction word
stim_thumb  in  1  1 = Thumb stimulus
stim_exp  in  THUMB_TW  expected type; ARM uses low ARM_TW bits
drv_instr  out  32  to decoder instruction
drv_thumb  out  1  to decoder thumb_mode
drv_valid  out  1  to decoder instr_valid
dec_valid  in  1  decoder decode_valid
dec_type  in  ARM_TW  decoder instr_type
dec_thumb_type  in  THUMB_TW  decoder thumb_instr_type
arm_pass, arm_fail, thumb_pass, thumb_fail  out  CNT_W each  result counters
orphan_cnt  out  CNT_W  dec_valid seen with FIFO empty
busy  out  1  state is RUN or DRAIN
done  out  1  state is DONE
timed_out  out  1  DONE was reached via timeout
all_pass  out  1  done & !timed_out & fails==0 & orphans==0 & (passes>0)
mm_valid  out  1  first mismatch captured
mm_instr  out  32  instruction of first mismatch
mm_exp, mm_got  out  THUMB_TW each  expected / observed type of first mismatch

Behaviour:
- Reset: state IDLE; all counters, flags and mm_* are 0; FIFO empty; drv_valid=0, drv_instr=0, drv_thumb=0; stim_ready=0.
- States: IDLE -start-> RUN; RUN -finish-> DRAIN; DRAIN -(FIFO empty)-> DONE; DRAIN -(idle counter reaches TIMEOUT)-> DONE with timed_out=1; DONE -start-> RUN. A start in any state clears results and FIFO and enters RUN; start has priority over finish.
- stim_ready = (state==RUN) & !full, combinational from registered state and count.
- On accept: push {instr, thumb, exp} to the FIFO. Next cycle, drv_instr and drv_thumb take the stimulus and drv_valid=1; otherwise drv_valid=0. The previous drv_instr and drv_thumb values are held.
- On dec_valid with FIFO non-empty: pop the head and compare. If the head is Thumb, compare dec_thumb_type with exp. If ARM, compare dec_type with exp[ARM_TW-1:0]. Increment the matching pass/fail counter.
- On the first fail only: set mm_valid and latch instr, exp and the observed type (ARM zero-extended). mm_* is sticky until start.
- On dec_valid with FIFO empty: orphan_cnt++ and no pop. dec_valid is ignored in IDLE and DONE.
- Push and pop in the same cycle are legal, including when full (ready is 0 then, so this is pop-only) and when empty (no bypass, so pop is orphan).
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- Counters saturate at all-ones and never wrap.
- The DRAIN idle counter resets on every dec_valid and increments otherwise. It is unused in other states.
- Compare latency: counters update 1 cycle after dec_valid.

Optional Feature:
Macro DECODE_CHECK_COV_EN.
- Defined: adds outputs arm_cov[2**ARM_TW-1:0] and thumb_cov[2**THUMB_TW-1:0]. A passing compare sets bit [exp]. The bitmaps clear on start and reset.
- Undefined: both ports exist but are tied to 0, and no coverage flops are built.

Test Plan:
- Reset, start, then push ARM 0xE0820001 exp=INSTR_DATA_PROC; the decoder returns it 1 cycle later -> arm_pass=1. After finish -> done=1, all_pass=1.
- Push Thumb 0x4700 exp=THUMB_ALU_HI with dec_thumb_type returning THUMB_BRANCH_UNCOND -> thumb_fail=1, mm_valid=1, mm_instr=0x00004700, mm_got=THUMB_BRANCH_UNCOND, all_pass=0 at done.
- Hold dec_valid low, push DEPTH=4 stimuli -> stim_ready drops after the 4th. Pulse dec_valid once -> ready returns. 5 results in order -> 5 passes.
- finish with 2 entries outstanding and no dec_valid for 64 cycles -> done=1, timed_out=1, all_pass=0.
- dec_valid in RUN with FIFO empty -> orphan_cnt=1, pass/fail counters unchanged.
- With DECODE_CHECK_COV_EN: pass 0xEF000000 exp=INSTR_SWI -> arm_cov[INSTR_SWI]=1. start -> arm_cov=0.
